// File: rtl/ana_pad_pkg.sv
// Shared types and constants for the analog pad switch sequencer.
package ana_pad_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BREAK  = 2'd1,
        SETTLE = 2'd2,
        CONN   = 2'd3
    } ana_sw_state_t;

    // Series-resistance path encodings driven on RSEL
    localparam logic [1:0] RSEL_50  = 2'd0;
    localparam logic [1:0] RSEL_200 = 2'd1;
    localparam logic [1:0] RSEL_500 = 2'd2;
    localparam logic [1:0] RSEL_1K5 = 2'd3;

endpackage

// File: rtl/ana_pad_switch_ctrl_if.sv
// Connect/disconnect request channel with valid/ready handshake.
interface ana_pad_switch_ctrl_if #(
    parameter int unsigned CHW = 3
);

    logic           REQ_VALID;
    logic           REQ_READY;
    logic           REQ_EN;
    logic [CHW-1:0] REQ_CH;
    logic [1:0]     REQ_RSEL;

    modport master (
        output REQ_VALID,
        output REQ_EN,
        output REQ_CH,
        output REQ_RSEL,
        input  REQ_READY
    );

    modport slave (
        input  REQ_VALID,
        input  REQ_EN,
        input  REQ_CH,
        input  REQ_RSEL,
        output REQ_READY
    );

endinterface

// File: rtl/ana_pad_timer.sv
// Loadable down-counter; done is high during the last cycle of the loaded interval.
module ana_pad_timer #(
    parameter int unsigned CNTW = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            load,
    input  logic [CNTW-1:0] value,
    output logic            done
);

    logic [CNTW-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Loaded with N at edge T, done is seen at edge T+N so the interval spans N cycles
    assign done = (cnt_q == CNTW'(1));

endmodule

// File: rtl/ana_pad_switch_ctrl.sv
// Break-before-make sequencer for a bank of analog pads with selectable series resistance.
module ana_pad_switch_ctrl
    import ana_pad_pkg::*;
#(
    parameter int unsigned NCH        = 8,
    parameter int unsigned CHW        = $clog2(NCH),
    parameter int unsigned BREAK_CYC  = 4,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned CNTW       = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    ana_pad_switch_ctrl_if.slave req,
    output logic [NCH-1:0]       SW_EN,
    output logic [1:0]           RSEL,
    output logic                 BUSY,
    output logic                 SETTLED,
    output logic                 ERR
);

    localparam logic [CNTW-1:0] BREAK_V  = CNTW'(BREAK_CYC);
    localparam logic [CNTW-1:0] SETTLE_V = CNTW'(SETTLE_CYC);
    localparam logic [CHW:0]    NCH_LIM  = (CHW + 1)'(NCH);
    localparam logic [NCH-1:0]  ONE      = NCH'(1);

    ana_sw_state_t   state_q;
    logic [NCH-1:0]  sw_en_q;
    logic [1:0]      rsel_q;
    logic            busy_q;
    logic            settled_q;
    logic            err_q;
    logic            ready_q;
    logic            tgt_en_q;
    logic [CHW-1:0]  tgt_ch_q;
    logic [1:0]      tgt_rsel_q;

    logic            accept;
    logic            ch_ok;
    logic            same_tgt;
    logic            reject;
    logic            noop;
    logic            start;
    logic            make;
    logic            tmr_load;
    logic [CNTW-1:0] tmr_value;
    logic            tmr_done;

    // Request classification; ready_q is only high in IDLE/CONN so accept implies one of those
    always_comb begin
        accept    = req.REQ_VALID && ready_q;
        ch_ok     = ({1'b0, req.REQ_CH} < NCH_LIM);
        same_tgt  = (state_q == CONN) && (req.REQ_CH == tgt_ch_q)
                    && (req.REQ_RSEL == tgt_rsel_q);
        reject    = accept && req.REQ_EN && !ch_ok;
        noop      = req.REQ_EN ? same_tgt : (state_q == IDLE);
        start     = accept && !reject && !noop;
        make      = (state_q == BREAK) && tmr_done && tgt_en_q;
        tmr_load  = start || make;
        tmr_value = start ? BREAK_V : SETTLE_V;
    end

    ana_pad_timer #(
        .CNTW (CNTW)
    ) u_timer (
        .CLK   (CLK),
        .RST   (RST),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            sw_en_q    <= '0;
            rsel_q     <= RSEL_50;
            busy_q     <= 1'b0;
            settled_q  <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            tgt_en_q   <= 1'b0;
            tgt_ch_q   <= '0;
            tgt_rsel_q <= RSEL_50;
        end else begin
            err_q <= reject;
            unique case (state_q)
                IDLE, CONN: begin
                    ready_q <= !start;
                    if (start) begin
                        state_q    <= BREAK;
                        sw_en_q    <= '0;
                        settled_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        tgt_en_q   <= req.REQ_EN;
                        tgt_ch_q   <= req.REQ_CH;
                        tgt_rsel_q <= req.REQ_RSEL;
                    end
                end
                BREAK: begin
                    if (tmr_done) begin
                        if (tgt_en_q) begin
                            // RSEL moves on the make edge, never while a switch is closed
                            state_q <= SETTLE;
                            sw_en_q <= ONE << tgt_ch_q;
                            rsel_q  <= tgt_rsel_q;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (tmr_done) begin
                        state_q   <= CONN;
                        settled_q <= 1'b1;
                        busy_q    <= 1'b0;
                        ready_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req.REQ_READY = ready_q;
    assign SW_EN         = sw_en_q;
    assign RSEL          = rsel_q;
    assign BUSY          = busy_q;
    assign SETTLED       = settled_q;
    assign ERR           = err_q;

endmodule

// File: tb/tb_ana_pad_switch_ctrl.sv
// Bench for ana_pad_switch_ctrl: timestamp-based reference model plus directed literal checks.
module tb_ana_pad_switch_ctrl;

    // NCH=6 keeps REQ_CH 3 bits wide while leaving channels 6 and 7 out of range
    localparam int NCH = 6;
    localparam int CHW = 3;
    localparam int BRK = 4;
    localparam int STL = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    ana_pad_switch_ctrl_if #(.CHW(CHW)) rq ();

    logic [NCH-1:0] sw;
    logic [1:0]     rsel;
    logic           busy;
    logic           settled;
    logic           err;

    ana_pad_switch_ctrl #(
        .NCH        (NCH),
        .BREAK_CYC  (BRK),
        .SETTLE_CYC (STL),
        .CNTW       (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .req     (rq),
        .SW_EN   (sw),
        .RSEL    (rsel),
        .BUSY    (busy),
        .SETTLED (settled),
        .ERR     (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nedge(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Reference model: an accepted sequence is a timestamp; outputs follow from elapsed edges
    initial begin : model
        int  e;
        int  k;
        bit  in_seq;
        int  t_acc;
        bit  p_en;
        int  p_ch;
        int  p_rsel;
        int  conn_ch;
        int  conn_rsel;
        int  m_rsel;
        bit  m_err;
        bit  m_ready;
        bit  on;
        int  exp_sw;
        e = 0; in_seq = 0; t_acc = 0; p_en = 0; p_ch = 0; p_rsel = 0;
        conn_ch = -1; conn_rsel = 0; m_rsel = 0; m_err = 0; m_ready = 0; on = 0;
        forever begin
            @(posedge CLK);
            e++;
            if (RST) begin
                in_seq = 0; conn_ch = -1; m_rsel = 0; m_err = 0; m_ready = 0; on = 1;
            end else begin
                m_err = 0;
                if (m_ready && rq.REQ_VALID) begin
                    if (rq.REQ_EN && int'(rq.REQ_CH) >= NCH) begin
                        m_err = 1;
                    end else if (rq.REQ_EN && conn_ch == int'(rq.REQ_CH)
                                 && conn_rsel == int'(rq.REQ_RSEL)) begin
                        m_err = 0;
                    end else if (!rq.REQ_EN && conn_ch < 0) begin
                        m_err = 0;
                    end else begin
                        in_seq  = 1;
                        t_acc   = e;
                        p_en    = rq.REQ_EN;
                        p_ch    = int'(rq.REQ_CH);
                        p_rsel  = int'(rq.REQ_RSEL);
                        conn_ch = -1;
                    end
                end
                if (in_seq) begin
                    k = e - t_acc;
                    if (p_en && k == BRK) m_rsel = p_rsel;
                    if ((!p_en && k == BRK) || (p_en && k == BRK + STL)) begin
                        in_seq = 0;
                        if (p_en) begin
                            conn_ch   = p_ch;
                            conn_rsel = p_rsel;
                        end
                    end
                end
                m_ready = !in_seq;
            end
            #1;
            if (on) begin
                if (!in_seq && conn_ch >= 0)
                    exp_sw = 1 << conn_ch;
                else if (in_seq && p_en && (e - t_acc) >= BRK)
                    exp_sw = 1 << p_ch;
                else
                    exp_sw = 0;
                chk("model_sw_en",   32'(sw),            32'(exp_sw));
                chk("model_rsel",    32'(rsel),          32'(m_rsel));
                chk("model_busy",    32'(busy),          32'(in_seq && !RST));
                chk("model_settled", 32'(settled),       32'(!in_seq && conn_ch >= 0));
                chk("model_err",     32'(err),           32'(m_err));
                chk("model_ready",   32'(rq.REQ_READY),  32'(m_ready));
                chk("onehot_or_zero", 32'($countones(sw) <= 1), 32'(1));
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the accept edge
    task automatic send(input bit en, input int ch, input int rs);
        int w;
        w = 0;
        rq.REQ_VALID = 1'b1;
        rq.REQ_EN    = en;
        rq.REQ_CH    = CHW'(ch);
        rq.REQ_RSEL  = 2'(rs);
        while (!rq.REQ_READY && w < 100) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: REQ_READY stayed 0 for %0d cycles, expected 1", w);
        end
        @(posedge CLK);
        @(negedge CLK);
        rq.REQ_VALID = 1'b0;
    endtask

    initial begin : stim
        int last_ch;
        int last_rs;
        bit en;
        int ch;
        int rs;
        rq.REQ_VALID = 1'b0;
        rq.REQ_EN    = 1'b0;
        rq.REQ_CH    = '0;
        rq.REQ_RSEL  = '0;
        RST = 1'b1;
        nedge(3);
        chk("rst_ready",   32'(rq.REQ_READY), 0);
        chk("rst_sw_en",   32'(sw),           0);
        chk("rst_rsel",    32'(rsel),         0);
        chk("rst_busy",    32'(busy),         0);
        chk("rst_settled", 32'(settled),      0);
        chk("rst_err",     32'(err),          0);
        RST = 1'b0;
        nedge(1);
        chk("ready_after_release", 32'(rq.REQ_READY), 1);

        // Connect ch3 through 500 ohm path
        send(1'b1, 3, 2);
        chk("c3_ready_low", 32'(rq.REQ_READY), 0);
        chk("c3_busy",      32'(busy),         1);
        chk("c3_sw_open",   32'(sw),           0);
        nedge(3);
        chk("c3_sw_still_open", 32'(sw), 0);
        nedge(1);
        chk("c3_sw_make",    32'(sw),      32'h08);
        chk("c3_rsel_make",  32'(rsel),    2);
        chk("c3_not_settled", 32'(settled), 0);
        nedge(15);
        chk("c3_settled_early", 32'(settled),      0);
        chk("c3_ready_early",   32'(rq.REQ_READY), 0);
        nedge(1);
        chk("c3_settled", 32'(settled),      1);
        chk("c3_ready",   32'(rq.REQ_READY), 1);
        chk("c3_idle_bus", 32'(busy),        0);

        // Move to ch5 via 200 ohm
        send(1'b1, 5, 1);
        chk("c5_break_sw",   32'(sw),   0);
        chk("c5_break_rsel", 32'(rsel), 2);
        nedge(3);
        chk("c5_break_sw_end",   32'(sw),   0);
        chk("c5_break_rsel_end", 32'(rsel), 2);
        nedge(1);
        chk("c5_make_sw",   32'(sw),   32'h20);
        chk("c5_make_rsel", 32'(rsel), 1);
        nedge(16);
        chk("c5_settled", 32'(settled), 1);

        // Out-of-range channel
        send(1'b1, 7, 0);
        chk("bad_err",     32'(err),          1);
        chk("bad_sw",      32'(sw),           32'h20);
        chk("bad_rsel",    32'(rsel),         1);
        chk("bad_settled", 32'(settled),      1);
        chk("bad_ready",   32'(rq.REQ_READY), 1);
        nedge(1);
        chk("bad_err_pulse", 32'(err), 0);

        // Identical request is a no-op
        send(1'b1, 5, 1);
        chk("same_settled", 32'(settled),      1);
        chk("same_ready",   32'(rq.REQ_READY), 1);
        chk("same_busy",    32'(busy),         0);
        chk("same_sw",      32'(sw),           32'h20);

        // Disconnect
        send(1'b0, 0, 0);
        chk("dis_sw",      32'(sw),      0);
        chk("dis_settled", 32'(settled), 0);
        chk("dis_busy",    32'(busy),    1);
        nedge(3);
        chk("dis_ready_low", 32'(rq.REQ_READY), 0);
        nedge(1);
        chk("dis_ready", 32'(rq.REQ_READY), 1);
        chk("dis_busy_end", 32'(busy),      0);
        chk("dis_rsel_kept", 32'(rsel),     1);

        // Disconnect while idle
        send(1'b0, 0, 0);
        chk("idle_dis_busy",  32'(busy),         0);
        chk("idle_dis_ready", 32'(rq.REQ_READY), 1);

        // Reset two cycles into settle
        send(1'b1, 2, 3);
        nedge(5);
        chk("pre_rst_sw", 32'(sw), 32'h04);
        RST = 1'b1;
        nedge(1);
        chk("mid_rst_sw",      32'(sw),           0);
        chk("mid_rst_rsel",    32'(rsel),         0);
        chk("mid_rst_busy",    32'(busy),         0);
        chk("mid_rst_settled", 32'(settled),      0);
        chk("mid_rst_ready",   32'(rq.REQ_READY), 0);
        RST = 1'b0;
        nedge(1);
        chk("mid_rst_release", 32'(rq.REQ_READY), 1);

        // Randomized traffic, including repeats, bad channels, back-to-back and resets
        last_ch = 0;
        last_rs = 0;
        for (int i = 0; i < 250; i++) begin
            nedge($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) begin
                en = 1'b1;
                ch = last_ch;
                rs = last_rs;
            end else begin
                en = ($urandom_range(0, 4) != 0);
                ch = $urandom_range(0, 7);
                rs = $urandom_range(0, 3);
            end
            send(en, ch, rs);
            if (en && ch < NCH) begin
                last_ch = ch;
                last_rs = rs;
            end
            if ($urandom_range(0, 15) == 0) begin
                nedge($urandom_range(0, 24));
                RST = 1'b1;
                nedge($urandom_range(1, 2));
                RST = 1'b0;
            end
        end
        nedge(30);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
